// File: rtl/dtw_ctrl.sv
// rtl/dtw_ctrl.sv - DTW core command controller: reference load / query batch sequencing with watchdog
module dtw_ctrl #(
  parameter int CNT_W     = 16,
  parameter int TIMEOUT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [31:0]      cmd_len,
  input  logic             abort,
  output logic             core_running,
  output logic             core_op_mode,
  output logic [31:0]      core_ref_len,
  input  logic             core_busy,
  input  logic             core_load_done,
  input  logic             core_sink_wren,
  output logic             ref_loaded,
  output logic [CNT_W-1:0] q_done_cnt,
  output logic             done_pulse,
  output logic             err,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_LOAD  = 3'd2,
    S_QUERY = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // Trip one count early so the timeout spans exactly 2^TIMEOUT_W-1 cycles.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state_q;
  logic [CNT_W-1:0]     target;
  logic [TIMEOUT_W-1:0] wdog;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 wd_expired;

  assign cnt_inc    = q_done_cnt + CNT_W'(1);
  assign wd_expired = (wdog == WD_LAST);
  assign cmd_ready  = (state_q == S_IDLE) && !abort;
  assign state      = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      core_running <= 1'b0;
      core_op_mode <= 1'b0;
      core_ref_len <= 32'd0;
      ref_loaded   <= 1'b0;
      q_done_cnt   <= '0;
      target       <= '0;
      done_pulse   <= 1'b0;
      err          <= 1'b0;
      wdog         <= '0;
    end else if (abort) begin
      state_q      <= S_IDLE;
      core_running <= 1'b0;
      done_pulse   <= 1'b0;
      err          <= 1'b0;
      wdog         <= '0;
    end else begin
      done_pulse <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            core_op_mode <= cmd_op;
            q_done_cnt   <= '0;
            wdog         <= '0;
            if (cmd_op) begin
              core_ref_len <= cmd_len;
              ref_loaded   <= 1'b0;
              state_q      <= S_ARM;
            end else begin
              target <= cmd_len[CNT_W-1:0];
              if (!ref_loaded) begin
                state_q <= S_ERR;
                err     <= 1'b1;
              end else if (cmd_len[CNT_W-1:0] == '0) begin
                state_q    <= S_DONE;
                done_pulse <= 1'b1;
              end else begin
                state_q <= S_ARM;
              end
            end
          end
        end
        S_ARM: begin
          wdog         <= '0;
          core_running <= 1'b1;
          state_q      <= core_op_mode ? S_LOAD : S_QUERY;
        end
        S_LOAD: begin
          if (core_load_done) begin
            ref_loaded   <= 1'b1;
            core_running <= 1'b0;
            wdog         <= '0;
            state_q      <= S_DRAIN;
          end else if (wd_expired) begin
            core_running <= 1'b0;
            err          <= 1'b1;
            state_q      <= S_ERR;
          end else begin
            wdog <= wdog + TIMEOUT_W'(1);
          end
        end
        S_QUERY: begin
          if (core_sink_wren) begin
            q_done_cnt <= cnt_inc;
            wdog       <= '0;
            if (cnt_inc == target) begin
              core_running <= 1'b0;
              state_q      <= S_DRAIN;
            end
          end else if (wd_expired) begin
            core_running <= 1'b0;
            err          <= 1'b1;
            state_q      <= S_ERR;
          end else begin
            wdog <= wdog + TIMEOUT_W'(1);
          end
        end
        S_DRAIN: begin
          if (!core_busy) begin
            wdog       <= '0;
            done_pulse <= 1'b1;
            state_q    <= S_DONE;
          end else if (wd_expired) begin
            err     <= 1'b1;
            state_q <= S_ERR;
          end else begin
            wdog <= wdog + TIMEOUT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        S_ERR: begin
          core_running <= 1'b0;
          err          <= 1'b1;
        end
        default: begin
          core_running <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dtw_ctrl.md
DTW_CTRL -- requirements
Module: dtw_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the query counter.
REQ-002 SHALL have parameter TIMEOUT_W, default 24: width of the watchdog counter. The timeout is 2^TIMEOUT_W-1 cycles without progress.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous reset, active-low.
REQ-005 SHALL have port cmd_valid, input, 1: host command present.
REQ-006 SHALL have port cmd_ready, output, 1: controller accepts a command.
REQ-007 SHALL have port cmd_op, input, 1: 1 = reference load, 0 = query batch.
REQ-008 SHALL have port cmd_len, input, 32: reference length for cmd_op=1; number of queries for cmd_op=0 (low CNT_W bits used).
REQ-009 SHALL have port abort, input, 1: synchronous abort request.
REQ-010 SHALL have port core_running, output, 1: drives dtw_core running.
REQ-011 SHALL have port core_op_mode, output, 1: drives dtw_core op_mode (0 query, 1 ref).
REQ-012 SHALL have port core_ref_len, output, 32: drives dtw_core ref_len.
REQ-013 SHALL have port core_busy, input, 1: dtw_core busy.
REQ-014 SHALL have port core_load_done, input, 1: dtw_core reference load complete.
REQ-015 SHALL have port core_sink_wren, input, 1: dtw_core result-write strobe; one pulse per query result.
REQ-016 SHALL have port ref_loaded, output, 1: a valid reference resides in the core.
REQ-017 SHALL have port q_done_cnt, output, CNT_W: results counted in the current batch.
REQ-018 SHALL have port done_pulse, output, 1: one-cycle command-complete strobe.
REQ-019 SHALL have port err, output, 1: sticky error flag.
REQ-020 SHALL have port state, output, 3: FSM state encoding for debug.

Function
REQ-021 SHALL implement the states IDLE=0, ARM=1, LOAD=2, QUERY=3, DRAIN=4, DONE=5, ERR=6.
REQ-022 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid && cmd_ready.
REQ-023 On accepting a command, SHALL latch cmd_op into core_op_mode, latch cmd_len into core_ref_len (cmd_op=1 only) and into the batch target (cmd_op=0 only), clear q_done_cnt, and go to ARM.
REQ-024 If an accepted query has ref_loaded=0, SHALL go to ERR instead of ARM.
REQ-025 If an accepted query has a zero target, SHALL go directly to DONE.
REQ-026 If an accepted command has cmd_op=1, SHALL clear ref_loaded in the accept cycle.
REQ-027 ARM SHALL last exactly 1 cycle with core_running=0, then go to LOAD (op=1) or QUERY (op=0). core_op_mode and core_ref_len are therefore stable at least 1 cycle before core_running rises.
REQ-028 SHALL assert core_running only in LOAD and QUERY, as a registered output. core_op_mode and core_ref_len SHALL NOT change while core_running=1.
REQ-029 LOAD: on core_load_done=1, SHALL set ref_loaded=1 and go to DRAIN.
REQ-030 QUERY: each core_sink_wren cycle SHALL increment q_done_cnt by 1 (wraps at 2^CNT_W).
REQ-031 QUERY: when the incremented count equals the target, SHALL go to DRAIN. Extra strobes after that point are not counted.
REQ-032 DRAIN: core_running=0; SHALL go to DONE on the first cycle with core_busy=0.
REQ-033 DONE: done_pulse=1 for exactly 1 cycle, then IDLE. done_pulse is 0 in every other state.
REQ-034 Watchdog: in LOAD, QUERY and DRAIN the watchdog increments every cycle. It clears on state entry, on core_load_done, and on core_sink_wren. At terminal count it SHALL go to ERR.
REQ-035 ERR: core_running=0, err=1, cmd_ready=0. The controller stays in ERR until abort.
REQ-036 abort SHALL take priority over every other transition: the next state is IDLE, core_running=0, err is cleared, and no done_pulse is produced. Aborting from LOAD leaves ref_loaded=0.
REQ-037 core_load_done and core_sink_wren SHALL be ignored outside LOAD and QUERY respectively.

Reset
REQ-038 While rst=0, SHALL asynchronously force: state=IDLE, core_running=0, core_op_mode=0, core_ref_len=0, ref_loaded=0, q_done_cnt=0, done_pulse=0, err=0, watchdog=0.
REQ-039 Reset asserted mid-operation SHALL drop core_running immediately (asynchronously). Release SHALL take effect on the next rising edge of clk.

Verification
REQ-040 Ref load: cmd_op=1, cmd_len=29898, core_load_done pulsed 40 cycles after running. Required: core_ref_len=29898 and core_op_mode=1 one cycle before core_running=1; ref_loaded=1; done_pulse once; IDLE.
REQ-041 Query batch: after ref load, cmd_op=0, cmd_len=3, three core_sink_wren pulses. Required: q_done_cnt=1,2,3; core_running falls after the 3rd pulse; with core_busy low 5 cycles later, done_pulse follows.
REQ-042 Query without reference: from reset, cmd_op=0, cmd_len=5. Required: ERR, err=1, core_running never 1; abort returns to IDLE with err=0.
REQ-043 Timeout: TIMEOUT_W=4, query with no sink strobes. Required: ERR after 15 cycles in QUERY; core_running=0.
REQ-044 Abort/reset mid-run: abort in LOAD. Required: IDLE next cycle, ref_loaded=0, no done_pulse. rst=0 mid-QUERY: all outputs equal reset values without a clock edge.
REQ-045 Zero-length query and handshake: cmd_len=0 with ref_loaded=1 gives done_pulse 1 cycle after acceptance; cmd_valid held through the accept gives exactly one acceptance per IDLE visit.
